// File: rtl/ysyx_23060061_mem_arbiter.sv
// ---------------------------------------------------------------------------
// ysyx_23060061_mem_arbiter
//
// Shares one downstream memory port between the instruction fetch unit (IFU)
// and the load/store unit (LSU). At most one transaction is outstanding. A
// granted request is latched and presented downstream. Its completion is
// returned to the requester that owns it as a one-cycle resp pulse. If the
// downstream never answers, the owner gets an error pulse after TIMEOUT_CYC
// cycles of waiting.
//
// Parameters:
//   TIMEOUT_CYC    response-wait cycles before error completion (2..65535)
//
// Ports:
//   clk, rst                  clock, synchronous active-low reset
//   ifu_req_*/ifu_addr        fetch request handshake and address
//   ifu_resp_valid            fetch completion pulse
//   lsu_req_*/lsu_wen/...     load/store request handshake and fields
//   lsu_resp_valid            load/store completion pulse
//   resp_rdata, resp_err      shared completion data/error, valid with a pulse
//   mem_req_*/mem_wen/...     downstream request handshake and latched fields
//   mem_resp_valid/mem_rdata  downstream completion and read data
//
// Configuration macro:
//   YSYX_23060061_MEM_ARB_RR_EN  when defined, simultaneous requests alternate
//                                (round robin). Otherwise the LSU always wins.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module ysyx_23060061_mem_arbiter #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ifu_req_valid,
  output logic        ifu_req_ready,
  input  logic [31:0] ifu_addr,
  output logic        ifu_resp_valid,
  input  logic        lsu_req_valid,
  output logic        lsu_req_ready,
  input  logic        lsu_wen,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  input  logic [3:0]  lsu_wmask,
  output logic        lsu_resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP
  } arbState_e;

  // The last count value before a response is declared lost.
  localparam logic [15:0] CntLast = 16'(TIMEOUT_CYC - 1);

  arbState_e   state;
  arbState_e   stateNext;
  logic        grantIfu;
  logic        grantLsu;
  logic        accept;
  logic        respDone;
  logic        respTimeout;
  logic        ownerLsu;
  logic [15:0] timeoutCnt;

`ifdef YSYX_23060061_MEM_ARB_RR_EN
  // Remembers who won the most recent accept. It starts at LSU, so the first
  // contested grant goes to the IFU.
  logic lastGrantLsu;

  always_ff @(posedge clk) begin
    if (!rst) begin
      lastGrantLsu <= 1'b1;
    end else if (accept) begin
      lastGrantLsu <= lsu_req_ready;
    end
  end
`endif

  // Pick the winner among the requesters that are valid this cycle. A lone
  // requester always wins. Only a tie uses the arbitration policy.
  always_comb begin
    grantLsu = 1'b0;
    grantIfu = 1'b0;
    if (lsu_req_valid && ifu_req_valid) begin
`ifdef YSYX_23060061_MEM_ARB_RR_EN
      grantLsu = !lastGrantLsu;
`else
      grantLsu = 1'b1;
`endif
      grantIfu = !grantLsu;
    end else begin
      grantLsu = lsu_req_valid;
      grantIfu = ifu_req_valid;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state logic and the combinational ready outputs. A ready signal is
  // raised only in IDLE and only for the winner. It is held low while reset is
  // asserted, so nothing looks accepted during reset.
  always_comb begin
    stateNext     = state;
    ifu_req_ready = 1'b0;
    lsu_req_ready = 1'b0;
    respDone      = 1'b0;
    respTimeout   = 1'b0;
    case (state)
      IDLE: begin
        ifu_req_ready = rst && grantIfu;
        lsu_req_ready = rst && grantLsu;
        if (grantIfu || grantLsu) begin
          stateNext = REQ;
        end
      end
      REQ: begin
        if (mem_req_ready) begin
          stateNext = RESP;
        end
      end
      RESP: begin
        // A real response arriving on the timeout cycle takes priority.
        if (mem_resp_valid) begin
          respDone  = 1'b1;
          stateNext = IDLE;
        end else if (timeoutCnt == CntLast) begin
          respTimeout = 1'b1;
          stateNext   = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  assign accept = ifu_req_ready || lsu_req_ready;

  // Registered datapath: the latched request fields, the wait counter, and the
  // completion pulse with its data. Completion data reads as zero except on a
  // successful load, so stores and timeouts return 0.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ownerLsu       <= 1'b0;
      timeoutCnt     <= 16'd0;
      mem_req_valid  <= 1'b0;
      mem_wen        <= 1'b0;
      mem_addr       <= 32'h0;
      mem_wdata      <= 32'h0;
      mem_wmask      <= 4'h0;
      ifu_resp_valid <= 1'b0;
      lsu_resp_valid <= 1'b0;
      resp_rdata     <= 32'h0;
      resp_err       <= 1'b0;
    end else begin
      ifu_resp_valid <= (respDone || respTimeout) && !ownerLsu;
      lsu_resp_valid <= (respDone || respTimeout) && ownerLsu;
      resp_err       <= respTimeout;
      resp_rdata     <= (respDone && !mem_wen) ? mem_rdata : 32'h0;
      if (accept) begin
        ownerLsu      <= lsu_req_ready;
        mem_req_valid <= 1'b1;
        mem_wen       <= lsu_req_ready && lsu_wen;
        mem_addr      <= lsu_req_ready ? lsu_addr : ifu_addr;
        mem_wdata     <= lsu_req_ready ? lsu_wdata : 32'h0;
        mem_wmask     <= lsu_req_ready ? lsu_wmask : 4'h0;
      end
      if (state == REQ && mem_req_ready) begin
        mem_req_valid <= 1'b0;
        timeoutCnt    <= 16'd0;
      end
      if (state == RESP && !respDone && !respTimeout) begin
        timeoutCnt <= timeoutCnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_23060061_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ysyx_23060061_mem_arbiter
//
// Testbench for ysyx_23060061_mem_arbiter, built with TIMEOUT_CYC=4.
// A transaction-level reference model tracks the outstanding request and
// predicts every output each cycle. Directed scenarios pin down concrete
// values and latencies. A randomized phase then exercises interleaved traffic,
// back-pressure, timeouts and random resets.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_ysyx_23060061_mem_arbiter;

  localparam int TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ifu_req_valid = 1'b0;
  logic        ifu_req_ready;
  logic [31:0] ifu_addr = 32'h0;
  logic        ifu_resp_valid;
  logic        lsu_req_valid = 1'b0;
  logic        lsu_req_ready;
  logic        lsu_wen = 1'b0;
  logic [31:0] lsu_addr = 32'h0;
  logic [31:0] lsu_wdata = 32'h0;
  logic [3:0]  lsu_wmask = 4'h0;
  logic        lsu_resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_resp_valid = 1'b0;
  logic [31:0] mem_rdata = 32'h0;

  ysyx_23060061_mem_arbiter #(.TIMEOUT_CYC(TIMEOUT)) dut (
    .clk            (clk),
    .rst            (rst),
    .ifu_req_valid  (ifu_req_valid),
    .ifu_req_ready  (ifu_req_ready),
    .ifu_addr       (ifu_addr),
    .ifu_resp_valid (ifu_resp_valid),
    .lsu_req_valid  (lsu_req_valid),
    .lsu_req_ready  (lsu_req_ready),
    .lsu_wen        (lsu_wen),
    .lsu_addr       (lsu_addr),
    .lsu_wdata      (lsu_wdata),
    .lsu_wmask      (lsu_wmask),
    .lsu_resp_valid (lsu_resp_valid),
    .resp_rdata     (resp_rdata),
    .resp_err       (resp_err),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_wen        (mem_wen),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_wmask      (mem_wmask),
    .mem_resp_valid (mem_resp_valid),
    .mem_rdata      (mem_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit modelOn = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after the rising edge. Samples are taken at 2.
  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // ------------------------------------------------------------------------
  // Reference model: one outstanding transaction, described by whether it is
  // still waiting to be handed downstream and how long it has waited for an
  // answer. The e* variables are the outputs predicted for the current cycle.
  // ------------------------------------------------------------------------
  bit          mBusy = 1'b0;
  bit          mSent = 1'b0;
  bit          mOwnerLsu = 1'b0;
  bit          mWen = 1'b0;
  bit          mLastLsu = 1'b1;
  logic [31:0] mAddr = 32'h0;
  logic [31:0] mWdata = 32'h0;
  logic [3:0]  mWmask = 4'h0;
  int          mWaited = 0;
  bit          eIfuResp = 1'b0;
  bit          eLsuResp = 1'b0;
  bit          eErr = 1'b0;
  bit          eMemValid = 1'b0;
  logic [31:0] eRdata = 32'h0;
  bit          winI;
  bit          winL;

  task automatic modelComplete(input bit err, input logic [31:0] data);
    eIfuResp = !mOwnerLsu;
    eLsuResp = mOwnerLsu;
    eErr     = err;
    eRdata   = data;
    mBusy    = 1'b0;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (modelOn) begin
        if (ifu_req_valid && lsu_req_valid) begin
`ifdef YSYX_23060061_MEM_ARB_RR_EN
          winL = !mLastLsu;
`else
          winL = 1'b1;
`endif
          winI = !winL;
        end else begin
          winI = ifu_req_valid;
          winL = lsu_req_valid;
        end

        checkOutput("ifuReady", ifu_req_ready, rst && !mBusy && winI);
        checkOutput("lsuReady", lsu_req_ready, rst && !mBusy && winL);
        checkOutput("ifuResp", ifu_resp_valid, eIfuResp);
        checkOutput("lsuResp", lsu_resp_valid, eLsuResp);
        if (eIfuResp || eLsuResp) begin
          checkOutput("respRdata", resp_rdata, eRdata);
          checkOutput("respErr", resp_err, eErr);
        end
        checkOutput("memReqValid", mem_req_valid, eMemValid);
        if (eMemValid) begin
          checkOutput("memWen", mem_wen, mWen);
          checkOutput("memAddr", mem_addr, mAddr);
          checkOutput("memWmask", mem_wmask, mWmask);
          if (mWen) checkOutput("memWdata", mem_wdata, mWdata);
        end

        // Predict the outputs that follow this clock edge.
        eIfuResp = 1'b0;
        eLsuResp = 1'b0;
        eErr     = 1'b0;
        eRdata   = 32'h0;
        if (!rst) begin
          mBusy     = 1'b0;
          mSent     = 1'b0;
          mLastLsu  = 1'b1;
          eMemValid = 1'b0;
        end else if (!mBusy) begin
          if (winI || winL) begin
            mBusy     = 1'b1;
            mSent     = 1'b0;
            mOwnerLsu = winL;
            mLastLsu  = winL;
            mWen      = winL && lsu_wen;
            mAddr     = winL ? lsu_addr : ifu_addr;
            mWdata    = lsu_wdata;
            mWmask    = winL ? lsu_wmask : 4'h0;
            eMemValid = 1'b1;
          end
        end else if (!mSent) begin
          if (mem_req_ready) begin
            mSent     = 1'b1;
            mWaited   = 0;
            eMemValid = 1'b0;
          end
        end else begin
          if (mem_resp_valid) begin
            modelComplete(1'b0, mWen ? 32'h0 : mem_rdata);
          end else begin
            mWaited++;
            if (mWaited >= TIMEOUT) modelComplete(1'b1, 32'h0);
          end
        end
      end
    end
  end

  // ------------------------------------------------------------------------
  // Directed scenarios with hand-computed expectations
  // ------------------------------------------------------------------------
  task automatic doReset();
    nextCycle();
    rst = 1'b0; ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    nextCycle();
    modelOn = 1'b1;
    nextCycle();
    rst = 1'b1;
  endtask

  task automatic testReset();
    nextCycle();
    rst = 1'b0; ifu_req_valid = 1'b1; lsu_req_valid = 1'b1;
    mem_req_ready = 1'b1; mem_resp_valid = 1'b1;
    nextCycle();
    #1;
    checkOutput("rstIfuReady", ifu_req_ready, 0);
    checkOutput("rstLsuReady", lsu_req_ready, 0);
    checkOutput("rstIfuResp", ifu_resp_valid, 0);
    checkOutput("rstLsuResp", lsu_resp_valid, 0);
    checkOutput("rstRdata", resp_rdata, 0);
    checkOutput("rstErr", resp_err, 0);
    checkOutput("rstMemValid", mem_req_valid, 0);
    checkOutput("rstMemWen", mem_wen, 0);
    checkOutput("rstMemAddr", mem_addr, 0);
    checkOutput("rstMemWdata", mem_wdata, 0);
    checkOutput("rstMemWmask", mem_wmask, 0);
    nextCycle();
    rst = 1'b1; ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
  endtask

  task automatic testIfuRead();
    nextCycle();
    mem_req_ready = 1'b1; mem_resp_valid = 1'b0; mem_rdata = 32'h00100073;
    ifu_req_valid = 1'b1; ifu_addr = 32'h80000000;
    #1;
    checkOutput("ifuRdAccept", ifu_req_ready, 1);
    nextCycle();
    ifu_req_valid = 1'b0;
    #1;
    checkOutput("ifuRdMemValid", mem_req_valid, 1);
    checkOutput("ifuRdMemAddr", mem_addr, 32'h80000000);
    checkOutput("ifuRdMemWen", mem_wen, 0);
    nextCycle();
    mem_resp_valid = 1'b1;
    #1;
    checkOutput("ifuRdNoEarlyResp", ifu_resp_valid, 0);
    nextCycle();
    mem_resp_valid = 1'b0;
    #1;
    checkOutput("ifuRdRespAtN3", ifu_resp_valid, 1);
    checkOutput("ifuRdRdata", resp_rdata, 32'h00100073);
    checkOutput("ifuRdErr", resp_err, 0);
    checkOutput("ifuRdNoLsuResp", lsu_resp_valid, 0);
    nextCycle();
    #1;
    checkOutput("ifuRdPulseOnce", ifu_resp_valid, 0);
  endtask

  task automatic testLsuStore();
    nextCycle();
    mem_req_ready = 1'b1; mem_resp_valid = 1'b0; mem_rdata = 32'h12345678;
    lsu_req_valid = 1'b1; lsu_wen = 1'b1; lsu_addr = 32'h80001000;
    lsu_wdata = 32'hDEADBEEF; lsu_wmask = 4'hF;
    #1;
    checkOutput("stAccept", lsu_req_ready, 1);
    nextCycle();
    lsu_req_valid = 1'b0;
    #1;
    checkOutput("stMemValid", mem_req_valid, 1);
    checkOutput("stMemWen", mem_wen, 1);
    checkOutput("stMemAddr", mem_addr, 32'h80001000);
    checkOutput("stMemWdata", mem_wdata, 32'hDEADBEEF);
    checkOutput("stMemWmask", mem_wmask, 4'hF);
    nextCycle();
    mem_resp_valid = 1'b1;
    nextCycle();
    mem_resp_valid = 1'b0;
    #1;
    checkOutput("stLsuResp", lsu_resp_valid, 1);
    checkOutput("stRdataZero", resp_rdata, 0);
    checkOutput("stNoIfuResp", ifu_resp_valid, 0);
    lsu_wen = 1'b0;
  endtask

  task automatic testArbitration();
    bit expGrant[4];
    bit grants[4];
    int n = 0;
`ifdef YSYX_23060061_MEM_ARB_RR_EN
    expGrant[0] = 1'b0; expGrant[1] = 1'b1; expGrant[2] = 1'b0; expGrant[3] = 1'b1;
`else
    expGrant[0] = 1'b1; expGrant[1] = 1'b1; expGrant[2] = 1'b1; expGrant[3] = 1'b1;
`endif
    doReset();
    nextCycle();
    ifu_req_valid = 1'b1; lsu_req_valid = 1'b1; lsu_wen = 1'b0;
    ifu_addr = 32'h80000100; lsu_addr = 32'h80000200;
    mem_req_ready = 1'b1; mem_resp_valid = 1'b1; mem_rdata = 32'h0BADF00D;
    for (int c = 0; c < 40 && n < 4; c++) begin
      if (c > 0) nextCycle();
      #1;
      if (ifu_req_ready || lsu_req_ready) begin
        checkOutput("arbExclusive", ifu_req_ready & lsu_req_ready, 0);
        grants[n] = lsu_req_ready;
        n++;
      end
    end
    nextCycle();
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    checkOutput("arbGrantCount", n, 4);
    for (int i = 0; i < 4; i++) begin
      if (i < n) checkOutput($sformatf("arbGrant%0d", i), grants[i], expGrant[i]);
    end
    repeat (4) nextCycle();
    mem_resp_valid = 1'b0; mem_req_ready = 1'b0;
  endtask

  task automatic testTimeout();
    nextCycle();
    mem_req_ready = 1'b1; mem_resp_valid = 1'b0; mem_rdata = 32'hA5A5A5A5;
    ifu_req_valid = 1'b1; ifu_addr = 32'h80000040;
    nextCycle();
    ifu_req_valid = 1'b0;
    nextCycle();
    for (int k = 0; k < TIMEOUT; k++) begin
      #1;
      checkOutput($sformatf("toNoPulse%0d", k), ifu_resp_valid, 0);
      nextCycle();
    end
    #1;
    checkOutput("toPulse", ifu_resp_valid, 1);
    checkOutput("toErr", resp_err, 1);
    checkOutput("toRdataZero", resp_rdata, 0);
    nextCycle();
    #1;
    checkOutput("toPulseOnce", ifu_resp_valid, 0);
  endtask

  task automatic testResetMidTxn();
    nextCycle();
    lsu_req_valid = 1'b1; lsu_wen = 1'b0; lsu_addr = 32'h80002000;
    mem_req_ready = 1'b1; mem_resp_valid = 1'b0;
    nextCycle();
    lsu_req_valid = 1'b0;
    nextCycle();
    rst = 1'b0;
    nextCycle();
    rst = 1'b1; mem_resp_valid = 1'b1; mem_rdata = 32'h55AA55AA;
    #1;
    checkOutput("midRstNoLsuResp", lsu_resp_valid, 0);
    checkOutput("midRstNoIfuResp", ifu_resp_valid, 0);
    checkOutput("midRstMemValid", mem_req_valid, 0);
    checkOutput("midRstRdata", resp_rdata, 0);
    checkOutput("midRstMemAddr", mem_addr, 0);
    nextCycle();
    mem_resp_valid = 1'b0;
    #1;
    checkOutput("midRstNoLatePulse", lsu_resp_valid, 0);
    nextCycle();
    lsu_req_valid = 1'b1; lsu_addr = 32'h80002004; mem_rdata = 32'hCAFEF00D;
    #1;
    checkOutput("midRstReaccept", lsu_req_ready, 1);
    nextCycle();
    lsu_req_valid = 1'b0;
    nextCycle();
    mem_resp_valid = 1'b1;
    nextCycle();
    mem_resp_valid = 1'b0;
    #1;
    checkOutput("midRstLoadResp", lsu_resp_valid, 1);
    checkOutput("midRstLoadData", resp_rdata, 32'hCAFEF00D);
  endtask

  // ------------------------------------------------------------------------
  // Randomized traffic
  // ------------------------------------------------------------------------
  task automatic applyStimulus();
    ifu_req_valid  = ($urandom_range(0, 99) < 60);
    lsu_req_valid  = ($urandom_range(0, 99) < 50);
    ifu_addr       = $urandom;
    lsu_addr       = $urandom;
    lsu_wdata      = $urandom;
    lsu_wmask      = 4'($urandom);
    lsu_wen        = 1'($urandom_range(0, 1));
    mem_req_ready  = ($urandom_range(0, 99) < 50);
    mem_resp_valid = ($urandom_range(0, 99) < 25);
    mem_rdata      = $urandom;
    rst            = ($urandom_range(0, 199) != 0);
  endtask

  initial begin
    doReset();
    testReset();
    testIfuRead();
    testLsuStore();
    testArbitration();
    testTimeout();
    testResetMidTxn();
    for (int i = 0; i < 3000; i++) begin
      nextCycle();
      applyStimulus();
    end
    nextCycle();
    rst = 1'b1; ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    repeat (2) nextCycle();
    #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ysyx_23060061_mem_arbiter.md
YSYX_23060061_MEM_ARBITER -- requirements
Module: ysyx_23060061_mem_arbiter

Interface
REQ-001 Parameter SHALL be: TIMEOUT_CYC, default 255, response-wait cycles before error completion (legal 2..65535).
REQ-002 Port SHALL be: clk  in  1  single clock; all state updates on rising edge.
REQ-003 Port SHALL be: rst  in  1  synchronous active-low reset.
REQ-004 Port SHALL be: ifu_req_valid  in  1  fetch read request.
REQ-005 Port SHALL be: ifu_req_ready  out  1  fetch request accepted this cycle.
REQ-006 Port SHALL be: ifu_addr  in  32  fetch address.
REQ-007 Port SHALL be: ifu_resp_valid  out  1  one-cycle fetch completion pulse.
REQ-008 Port SHALL be: lsu_req_valid  in  1  load/store request.
REQ-009 Port SHALL be: lsu_req_ready  out  1  LSU request accepted this cycle.
REQ-010 Port SHALL be: lsu_wen  in  1  1 = store, 0 = load.
REQ-011 Port SHALL be: lsu_addr  in  32  load/store address.
REQ-012 Port SHALL be: lsu_wdata  in  32  store data.
REQ-013 Port SHALL be: lsu_wmask  in  4  store byte mask.
REQ-014 Port SHALL be: lsu_resp_valid  out  1  one-cycle LSU completion pulse.
REQ-015 Port SHALL be: resp_rdata  out  32  read data, shared by both requesters, valid with either resp pulse.
REQ-016 Port SHALL be: resp_err  out  1  timeout error flag, valid with either resp pulse.
REQ-017 Port SHALL be: mem_req_valid  out  1  downstream request.
REQ-018 Port SHALL be: mem_req_ready  in  1  downstream accepts request.
REQ-019 Port SHALL be: mem_wen, mem_addr, mem_wdata, mem_wmask  out  1/32/32/4  latched request fields.
REQ-020 Port SHALL be: mem_resp_valid  in  1  downstream completion.
REQ-021 Port SHALL be: mem_rdata  in  32  downstream read data.

Function
REQ-022 FSM SHALL have exactly three states: IDLE, REQ, RESP; one transaction outstanding at most.
REQ-023 In IDLE, ready SHALL be driven combinationally to the arbitration winner only; losers and non-IDLE states see ready=0.
REQ-024 On accept (valid&ready), the block SHALL latch addr/wen/wdata/wmask (IFU: wen=0, wmask=0) plus owner ID, and enter REQ.
REQ-025 In REQ, mem_req_valid SHALL be 1 with latched fields held stable; on mem_req_ready=1 go to RESP and clear the timeout counter.
REQ-026 In RESP, on mem_resp_valid=1 the owner's resp_valid SHALL pulse exactly one cycle later with resp_rdata=mem_rdata (0 for stores), resp_err=0; state returns to IDLE.
REQ-027 In RESP without mem_resp_valid, the counter SHALL increment each cycle; at TIMEOUT_CYC-1 the owner SHALL get a resp pulse with resp_err=1, resp_rdata=0, state to IDLE.
REQ-028 mem_resp_valid coinciding with timeout SHALL win (normal completion, err=0).
REQ-029 mem_resp_valid outside RESP SHALL be ignored.
REQ-030 Minimum latency SHALL be: accept cycle N, mem_req_valid N+1, resp pulse N+3 when downstream responds with no wait.
REQ-031 A new request SHALL be acceptable in the same cycle as the previous resp pulse.
REQ-032 Outputs resp_*, mem_* SHALL be registered; resp_valid outputs otherwise 0.

Reset
REQ-033 While rst=0 at an edge: state IDLE, all valid/ready outputs 0, resp_rdata 0, resp_err 0, mem_* 0, counter 0, last_grant=LSU.
REQ-034 Reset mid-transaction SHALL drop the transaction with no resp pulse.

Configuration
REQ-035 With YSYX_23060061_MEM_ARB_RR_EN defined: simultaneous requests SHALL be granted to the requester not in last_grant; last_grant updates on each accept.
REQ-036 Without YSYX_23060061_MEM_ARB_RR_EN: LSU SHALL always win simultaneous requests; last_grant unused.

Verification
REQ-037 Single IFU read addr 0x80000000, downstream ready/resp immediate, mem_rdata 0x00100073 -> ifu_resp_valid at N+3, resp_rdata 0x00100073, err 0.
REQ-038 LSU store addr 0x80001000 wdata 0xDEADBEEF wmask 0xF -> mem_wen=1 with those fields; lsu_resp_valid, resp_rdata 0.
REQ-039 Both valid for 4 transactions, RR off -> all LSU first; RR on -> grants IFU, LSU, IFU, LSU.
REQ-040 TIMEOUT_CYC=4, mem_resp_valid never asserted -> owner resp pulse with resp_err=1, rdata 0, 4 cycles after entering RESP.
REQ-041 rst=0 while in RESP, then mem_resp_valid=1 -> no resp pulse, all outputs 0, next request accepted normally.
